// File: rtl/io_bus_ctrl_if.sv
// CPU data-bus port of the memory-mapped I/O slave: address, store strobe/data,
// same-cycle read data and the window-select flag the CPU uses to pick I/O over memory.
interface io_bus_ctrl_if;
   logic [31:0] addr;
   logic        wrEn;
   logic [31:0] wrData;
   logic [31:0] rdData;
   logic        ioSel;

   modport master (output addr, output wrEn, output wrData, input rdData, input ioSel);
   modport slave  (input addr, input wrEn, input wrData, output rdData, output ioSel);
endinterface

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O slave: LEDs, seven-segment digits, synchronized switches/keys and a ms timer.
// Optional input debounce is built when DEBOUNCE_EN is defined.
module io_bus_ctrl #(
   parameter logic [31:0] IO_BASE    = 32'hF000_0000,
   parameter int          CLK_PER_MS = 50000,
   parameter int          DB_CYCLES  = 500000
) (
   input  logic            clk,
   input  logic            reset,
   io_bus_ctrl_if.slave    bus,
   input  logic [9:0]      SW,
   input  logic [3:0]      KEY,
   output logic [9:0]      LEDR,
   output logic [7:0]      LEDG,
   output logic [6:0]      HEX0,
   output logic [6:0]      HEX1,
   output logic [6:0]      HEX2,
   output logic [6:0]      HEX3
);

   localparam int PW = $clog2(CLK_PER_MS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

   localparam logic [9:0] OFF_HEX   = 10'h000;
   localparam logic [9:0] OFF_LEDR  = 10'h001;
   localparam logic [9:0] OFF_LEDG  = 10'h002;
   localparam logic [9:0] OFF_KDATA = 10'h004;
   localparam logic [9:0] OFF_KCTRL = 10'h005;
   localparam logic [9:0] OFF_SDATA = 10'h008;
   localparam logic [9:0] OFF_SCTRL = 10'h009;
   localparam logic [9:0] OFF_TCNT  = 10'h040;
   localparam logic [9:0] OFF_TLIM  = 10'h041;
   localparam logic [9:0] OFF_TCTL  = 10'h042;

   logic [15:0]   r_hex;
   logic [9:0]    r_ledr;
   logic [7:0]    r_ledg;
   logic [3:0]    r_key_s1, r_key_s2;
   logic [9:0]    r_sw_s1, r_sw_s2;
   logic [1:0]    r_kctrl, r_sctrl, r_tctl;
   logic [31:0]   r_tcnt, r_tlim;
   logic [PW-1:0] r_presc;

   logic          w_sel;
   logic [9:0]    w_off;
   logic          w_wr;
   logic          w_wr_kctrl, w_wr_sctrl, w_wr_tctl, w_wr_tcnt;
   logic [3:0]    w_kdata;
   logic [9:0]    w_sdata;
   logic          w_kset, w_sset;
   logic          w_tick, w_wrap;
   logic          w_unused_addr;

   assign w_sel         = (bus.addr[31:12] == IO_BASE[31:12]);
   assign w_off         = bus.addr[11:2];
   assign w_wr          = bus.wrEn & w_sel;
   assign w_wr_kctrl    = w_wr & (w_off == OFF_KCTRL);
   assign w_wr_sctrl    = w_wr & (w_off == OFF_SCTRL);
   assign w_wr_tctl     = w_wr & (w_off == OFF_TCTL);
   assign w_wr_tcnt     = w_wr & (w_off == OFF_TCNT);
   assign w_unused_addr = ^bus.addr[1:0];

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

   // {overrun, ready}: a set event beats a same-cycle write-0 clear
   function automatic logic [1:0] ctrl_next(input logic [1:0] cur, input logic set,
                                            input logic clr_rdy, input logic clr_ov);
      ctrl_next = {(set & cur[0]) | (cur[1] & ~clr_ov), set | (cur[0] & ~clr_rdy)};
   endfunction

   assign HEX0 = hex_seg(r_hex[3:0]);
   assign HEX1 = hex_seg(r_hex[7:4]);
   assign HEX2 = hex_seg(r_hex[11:8]);
   assign HEX3 = hex_seg(r_hex[15:12]);
   assign LEDR = r_ledr;
   assign LEDG = r_ledg;

   // Keys are stored inverted so the all-zero reset state means "nothing pressed"
   always_ff @(posedge clk) begin
      if (reset) begin
         r_key_s1 <= '0;
         r_key_s2 <= '0;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_key_s1 <= ~KEY;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= SW;
         r_sw_s2  <= r_sw_s1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LOAD = DBW'(DB_CYCLES - 1);

   logic [3:0]     r_kdb;
   logic [9:0]     r_sdb;
   logic [DBW-1:0] r_kcnt, r_scnt;

   assign w_kdata = r_kdb;
   assign w_sdata = r_sdb;
   assign w_kset  = (r_kcnt == '0) && (r_key_s2 != r_kdb);
   assign w_sset  = (r_scnt == '0) && (r_sw_s2 != r_sdb);

   // Down-counter reloads whenever the synced value is about to move
   always_ff @(posedge clk) begin
      if (reset) begin
         r_kdb  <= '0;
         r_kcnt <= '0;
         r_sdb  <= '0;
         r_scnt <= '0;
      end else begin
         if (w_kset) r_kdb <= r_key_s2;
         if (r_key_s1 != r_key_s2)
            r_kcnt <= DB_LOAD;
         else if ((r_kcnt != '0) && (r_key_s2 != r_kdb))
            r_kcnt <= r_kcnt - DBW'(1);
         if (w_sset) r_sdb <= r_sw_s2;
         if (r_sw_s1 != r_sw_s2)
            r_scnt <= DB_LOAD;
         else if ((r_scnt != '0) && (r_sw_s2 != r_sdb))
            r_scnt <= r_scnt - DBW'(1);
      end
   end
`else
   assign w_kdata = r_key_s2;
   assign w_sdata = r_sw_s2;
   assign w_kset  = (r_key_s1 != r_key_s2);
   assign w_sset  = (r_sw_s1 != r_sw_s2);
`endif

   assign w_tick = (r_presc == PRESC_LAST);
   assign w_wrap = w_tick && !w_wr_tcnt && (r_tlim != 32'd0) && (r_tcnt == r_tlim - 32'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hex  <= '0;
         r_ledr <= '0;
         r_ledg <= '0;
         r_tlim <= '0;
      end else if (w_wr) begin
         case (w_off)
            OFF_HEX:  r_hex  <= bus.wrData[15:0];
            OFF_LEDR: r_ledr <= bus.wrData[9:0];
            OFF_LEDG: r_ledg <= bus.wrData[7:0];
            OFF_TLIM: r_tlim <= bus.wrData;
            default:  ;
         endcase
      end
   end

   // A CPU load of TCNT restarts the millisecond phase and overrides any tick
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcnt  <= '0;
         r_presc <= '0;
      end else if (w_wr_tcnt) begin
         r_tcnt  <= bus.wrData;
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_tcnt  <= w_wrap ? 32'd0 : r_tcnt + 32'd1;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_kctrl <= '0;
         r_sctrl <= '0;
         r_tctl  <= '0;
      end else begin
         r_kctrl <= ctrl_next(r_kctrl, w_kset, w_wr_kctrl & ~bus.wrData[0], w_wr_kctrl & ~bus.wrData[2]);
         r_sctrl <= ctrl_next(r_sctrl, w_sset, w_wr_sctrl & ~bus.wrData[0], w_wr_sctrl & ~bus.wrData[2]);
         r_tctl  <= ctrl_next(r_tctl,  w_wrap, w_wr_tctl  & ~bus.wrData[0], w_wr_tctl  & ~bus.wrData[2]);
      end
   end

   always_comb begin
      bus.rdData = 32'd0;
      if (w_sel) begin
         case (w_off)
            OFF_HEX:   bus.rdData = {16'd0, r_hex};
            OFF_LEDR:  bus.rdData = {22'd0, r_ledr};
            OFF_LEDG:  bus.rdData = {24'd0, r_ledg};
            OFF_KDATA: bus.rdData = {28'd0, w_kdata};
            OFF_KCTRL: bus.rdData = {29'd0, r_kctrl[1], 1'b0, r_kctrl[0]};
            OFF_SDATA: bus.rdData = {22'd0, w_sdata};
            OFF_SCTRL: bus.rdData = {29'd0, r_sctrl[1], 1'b0, r_sctrl[0]};
            OFF_TCNT:  bus.rdData = r_tcnt;
            OFF_TLIM:  bus.rdData = r_tlim;
            OFF_TCTL:  bus.rdData = {29'd0, r_tctl[1], 1'b0, r_tctl[0]};
            default:   bus.rdData = 32'd0;
         endcase
      end
   end

   assign bus.ioSel = w_sel;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: directed register/timer/input scenarios followed by randomized
// bus traffic and pin activity, all checked against a cycle-level reference model.
module tb_io_bus_ctrl;
   localparam int CPM = 4;
   localparam int DBC = 8;
`ifdef DEBOUNCE_EN
   localparam int LAT = DBC + 2;
`else
   localparam int LAT = 2;
`endif

   localparam logic [31:0] A_HEX   = 32'hF000_0000;
   localparam logic [31:0] A_LEDR  = 32'hF000_0004;
   localparam logic [31:0] A_LEDG  = 32'hF000_0008;
   localparam logic [31:0] A_KDATA = 32'hF000_0010;
   localparam logic [31:0] A_KCTRL = 32'hF000_0014;
   localparam logic [31:0] A_SDATA = 32'hF000_0020;
   localparam logic [31:0] A_SCTRL = 32'hF000_0024;
   localparam logic [31:0] A_TCNT  = 32'hF000_0100;
   localparam logic [31:0] A_TLIM  = 32'hF000_0104;
   localparam logic [31:0] A_TCTL  = 32'hF000_0108;

   logic clk = 1'b0;
   logic reset;
   logic [9:0] SW;
   logic [3:0] KEY;
   logic [9:0] LEDR;
   logic [7:0] LEDG;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;

   always #5 clk = ~clk;

   io_bus_ctrl_if bus();

   io_bus_ctrl #(.IO_BASE(32'hF000_0000), .CLK_PER_MS(CPM), .DB_CYCLES(DBC)) dut (
      .clk(clk), .reset(reset), .bus(bus), .SW(SW), .KEY(KEY),
      .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [31:0] addrs [14] = '{A_HEX, A_LEDR, A_LEDG, A_KDATA, A_KCTRL, A_SDATA, A_SCTRL,
                               A_TCNT, A_TLIM, A_TCTL, 32'hF000_000C, 32'hF000_0FFC,
                               32'hE000_0100, 32'hF000_1004};

   // Reference model state
   logic [15:0] m_hex;
   logic [9:0]  m_ledr;
   logic [7:0]  m_ledg;
   logic [31:0] m_tcnt, m_tlim, m_kctrl, m_sctrl, m_tctl;
   int          m_n = 40;
   int          m_t0 = 40;
   logic [3:0]  khist [32];
   logic [9:0]  shist [32];

   function automatic logic [3:0] exp_kdata();
      return khist[(m_n - LAT + 1) & 31];
   endfunction

   function automatic logic [9:0] exp_sdata();
      return shist[(m_n - LAT + 1) & 31];
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      if (a[31:12] != 20'hF0000) return 32'd0;
      case ({a[11:2], 2'b00})
         12'h000: return {16'd0, m_hex};
         12'h004: return {22'd0, m_ledr};
         12'h008: return {24'd0, m_ledg};
         12'h010: return {28'd0, exp_kdata()};
         12'h014: return m_kctrl;
         12'h020: return {22'd0, exp_sdata()};
         12'h024: return m_sctrl;
         12'h100: return m_tcnt;
         12'h104: return m_tlim;
         12'h108: return m_tctl;
         default: return 32'd0;
      endcase
   endfunction

   // ready = bit0, overrun = bit2; an event beats a same-cycle clear
   function automatic logic [31:0] ctrl_upd(input logic [31:0] cur, input bit ev,
                                            input bit wr, input logic [31:0] d);
      bit rdy, ov;
      rdy = ev || (cur[0] && !(wr && !d[0]));
      ov  = (ev && cur[0]) || (cur[2] && !(wr && !d[2]));
      return {29'd0, ov, 1'b0, rdy};
   endfunction

   task automatic model_edge();
      bit w, kev, sev, tick, wrap;
      logic [11:0] off;
      logic [31:0] d, nt;
      m_n++;
      if (reset) begin
         m_hex = '0; m_ledr = '0; m_ledg = '0;
         m_tcnt = '0; m_tlim = '0; m_kctrl = '0; m_sctrl = '0; m_tctl = '0;
         m_t0 = m_n;
         for (int i = 0; i < 32; i++) begin khist[i] = '0; shist[i] = '0; end
         return;
      end
      khist[m_n & 31] = ~KEY;
      shist[m_n & 31] = SW;
      kev  = khist[(m_n - LAT + 1) & 31] != khist[(m_n - LAT) & 31];
      sev  = shist[(m_n - LAT + 1) & 31] != shist[(m_n - LAT) & 31];
      w    = bus.wrEn && (bus.addr[31:12] == 20'hF0000);
      off  = {bus.addr[11:2], 2'b00};
      d    = bus.wrData;
      tick = ((m_n - m_t0) % CPM) == 0;
      wrap = 0;
      nt   = m_tcnt;
      if (w && off == 12'h100) begin
         nt = d;
         m_t0 = m_n;
      end else if (tick) begin
         if (m_tlim != 0 && m_tcnt == m_tlim - 1) begin nt = 0; wrap = 1; end
         else nt = m_tcnt + 1;
      end
      m_kctrl = ctrl_upd(m_kctrl, kev, w && off == 12'h014, d);
      m_sctrl = ctrl_upd(m_sctrl, sev, w && off == 12'h024, d);
      m_tctl  = ctrl_upd(m_tctl, wrap, w && off == 12'h108, d);
      if (w) begin
         case (off)
            12'h000: m_hex  = d[15:0];
            12'h004: m_ledr = d[9:0];
            12'h008: m_ledg = d[7:0];
            12'h104: m_tlim = d;
            default: ;
         endcase
      end
      m_tcnt = nt;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check pre-edge state, clock, advance model
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.addr = a; bus.wrEn = we; bus.wrData = d;
      #2;
      chk("rdData", bus.rdData, exp_rd(a));
      chk("ioSel", {31'd0, bus.ioSel}, {31'd0, a[31:12] == 20'hF0000});
      chk("LEDR", {22'd0, LEDR}, {22'd0, m_ledr});
      chk("LEDG", {24'd0, LEDG}, {24'd0, m_ledg});
      chk("HEX0", {25'd0, HEX0}, {25'd0, SEG[m_hex[3:0]]});
      chk("HEX1", {25'd0, HEX1}, {25'd0, SEG[m_hex[7:4]]});
      chk("HEX2", {25'd0, HEX2}, {25'd0, SEG[m_hex[11:8]]});
      chk("HEX3", {25'd0, HEX3}, {25'd0, SEG[m_hex[15:12]]});
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      int hold;
      logic [31:0] a, d;
      logic we;
      reset = 1'b1; SW = '0; KEY = 4'hF;
      bus.addr = '0; bus.wrEn = 1'b0; bus.wrData = '0;
      @(posedge clk);
      model_edge();
      #1;
      step(1'b0, A_HEX, 32'd0);
      reset = 1'b0;
      chk("rst_hex0", {25'd0, HEX0}, 32'h40);
      chk("rst_ledr", {22'd0, LEDR}, 32'd0);
      step(1'b0, A_TCNT, 32'd0);

      // Hex digits
      step(1'b1, A_HEX, 32'h0000_1234);
      chk("t1_hex0", {25'd0, HEX0}, {25'd0, 7'b0011001});
      chk("t1_hex3", {25'd0, HEX3}, {25'd0, 7'b1111001});
      chk("t1_rd", bus.rdData, 32'h1234);

      // LEDs and an unmapped hole
      step(1'b1, A_LEDR, 32'h3FF);
      step(1'b1, A_LEDG, 32'hAA);
      step(1'b0, 32'hF000_000C, 32'd0);
      chk("t2_ledr", {22'd0, LEDR}, 32'h3FF);
      chk("t2_ledg", {24'd0, LEDG}, 32'hAA);
      chk("t2_hole", bus.rdData, 32'd0);
      chk("t2_iosel", {31'd0, bus.ioSel}, 32'd1);

      // Key press, overrun, clear
      KEY = 4'hE;
      repeat (LAT - 1) step(1'b0, A_KCTRL, 32'd0);
      chk("t3_kctrl_early", bus.rdData, 32'd0);
      step(1'b0, A_KCTRL, 32'd0);
      chk("t3_kctrl", bus.rdData, 32'd1);
      step(1'b0, A_KDATA, 32'd0);
      chk("t3_kdata", bus.rdData, 32'd1);
      KEY = 4'hC;
      repeat (LAT) step(1'b0, A_KCTRL, 32'd0);
      chk("t3_kctrl_ov", bus.rdData, 32'd5);
      step(1'b1, A_KCTRL, 32'd0);
      chk("t3_kctrl_clr", bus.rdData, 32'd0);

      // Timer wrap at TLIM=3; edge numbers relative to the TCNT load
      step(1'b1, A_TCTL, 32'd0);
      step(1'b1, A_TCNT, 32'd0);
      step(1'b1, A_TLIM, 32'd3);
      repeat (10) step(1'b0, A_TCNT, 32'd0);
      chk("t4_tcnt", bus.rdData, 32'd2);
      step(1'b0, A_TCTL, 32'd0);
      chk("t4_tctl", bus.rdData, 32'd1);
      repeat (11) step(1'b0, A_TCNT, 32'd0);
      step(1'b0, A_TCTL, 32'd0);
      chk("t4_tctl_ov", bus.rdData, 32'd5);

      // Clear colliding with a wrap; TCNT load colliding with a tick
      step(1'b1, A_TCTL, 32'd0);
      repeat (10) step(1'b0, A_TCNT, 32'd0);
      step(1'b1, A_TCTL, 32'd0);
      chk("t5_tctl_set_wins", bus.rdData, 32'd1);
      repeat (3) step(1'b0, A_TCNT, 32'd0);
      step(1'b1, A_TCNT, 32'd7);
      chk("t5_tcnt_load", bus.rdData, 32'd7);

      // Mid-run reset
      step(1'b1, A_LEDR, 32'h155);
      repeat (5) step(1'b0, A_TCNT, 32'd0);
      reset = 1'b1;
      step(1'b0, A_TCNT, 32'd0);
      reset = 1'b0;
      chk("t6_ledr", {22'd0, LEDR}, 32'd0);
      chk("t6_hex0", {25'd0, HEX0}, 32'h40);
      chk("t6_hex3", {25'd0, HEX3}, 32'h40);
      chk("t6_tcnt", bus.rdData, 32'd0);

      // Randomized traffic
      hold = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold == 0) begin
            SW = 10'($urandom);
            KEY = 4'($urandom);
            hold = $urandom_range(12, 30);
         end else begin
            hold--;
         end
         a  = addrs[$urandom_range(0, 13)] | 32'($urandom_range(0, 3));
         we = ($urandom_range(0, 3) == 0);
         d  = $urandom;
         if (a[31:2] == A_TLIM[31:2]) d = 32'($urandom_range(0, 6));
         if (a[31:2] == A_TCNT[31:2])
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : 32'hFFFF_FFFD;
         step(we, a, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
